// File: rtl/next_state_selector_pkg.sv
// Shared control-unit constants for the microsequencer: address width default,
// sequencing opcodes and condition source bit positions.
package next_state_selector_pkg;

  localparam int DEFAULT_ADDR_W = 10;

  localparam logic [2:0] NS_ENCODE  = 3'd0;
  localparam logic [2:0] NS_JUMP    = 3'd1;
  localparam logic [2:0] NS_INC     = 3'd2;
  localparam logic [2:0] NS_CBRANCH = 3'd3;
  localparam logic [2:0] NS_WAIT    = 3'd4;
  localparam logic [2:0] NS_CALL    = 3'd5;
  localparam logic [2:0] NS_RETURN  = 3'd6;
  localparam logic [2:0] NS_RESTART = 3'd7;

  localparam int COND_MOC  = 0;
  localparam int COND_BR   = 1;
  localparam int COND_IR   = 2;
  localparam int COND_TRUE = 3;

endpackage

// File: rtl/next_state_selector_if.sv
// Microword/sequencer bundle between the microstore (master) and the
// next-state selector (slave).
interface next_state_selector_if
  import next_state_selector_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int STACK_DEPTH = 4
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0]  current_state;
  logic [2:0]         ns_sel;
  logic               inv;
  logic [1:0]         cond_sel;
  logic [ADDR_W-1:0]  cr_addr;
  logic [3:0]         cond_in;
  logic [ADDR_W-1:0]  encoder_state;
  logic [ADDR_W-1:0]  next_state;
  logic               stack_err;
  logic [DEPTH_W-1:0] stack_depth;

  modport master (
    output current_state, ns_sel, inv, cond_sel, cr_addr, cond_in, encoder_state,
    input  next_state, stack_err, stack_depth
  );

  modport slave (
    input  current_state, ns_sel, inv, cond_sel, cr_addr, cond_in, encoder_state,
    output next_state, stack_err, stack_depth
  );

endinterface

// File: rtl/next_state_selector_micro_return_stack.sv
// Small LIFO of micro-return addresses; overflowing pushes and underflowing pops
// are ignored here and reported by the caller.
module micro_return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10,
  localparam int DEPTH_W = $clog2(DEPTH + 1),
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] ptr_reg;
  logic [DEPTH_W-1:0] top_ptr;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               do_push;
  logic               do_pop;

  assign full    = (ptr_reg == DEPTH_W'(DEPTH));
  assign empty   = (ptr_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign top_ptr = ptr_reg - 1'b1;
  assign wr_idx  = ptr_reg[IDX_W-1:0];
  assign rd_idx  = top_ptr[IDX_W-1:0];
  // Top entry is read combinationally so RETURN can jump in the same cycle.
  assign dout    = mem[rd_idx];
  assign depth   = ptr_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (do_push) begin
      ptr_reg <= ptr_reg + 1'b1;
    end else if (do_pop) begin
      ptr_reg <= ptr_reg - 1'b1;
    end
  end

endmodule

// File: rtl/next_state_selector.sv
// Microsequencer next-state stage: selects and registers the following microstore
// address, breaking the microstore/sequencer combinational loop.
module next_state_selector
  import next_state_selector_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_STATE = 0,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  next_state_selector_if.slave bus
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_STATE);

  logic [ADDR_W-1:0]  next_state_reg;
  logic [ADDR_W-1:0]  next_state_next;
  logic               stack_err_reg;
  logic               err_set;
  logic [ADDR_W-1:0]  inc;
  logic               c;
  logic               push;
  logic               pop;
  logic [ADDR_W-1:0]  stack_dout;
  logic [DEPTH_W-1:0] depth;
  logic               stack_full;
  logic               stack_empty;

  assign inc = bus.current_state + 1'b1;
  assign c   = bus.cond_in[bus.cond_sel] ^ bus.inv;

  always_comb begin
    next_state_next = next_state_reg;
    push            = 1'b0;
    pop             = 1'b0;
    err_set         = 1'b0;
    case (bus.ns_sel)
      NS_ENCODE:  next_state_next = bus.encoder_state;
      NS_JUMP:    next_state_next = bus.cr_addr;
      NS_INC:     next_state_next = inc;
      NS_CBRANCH: next_state_next = c ? bus.cr_addr : inc;
      NS_WAIT:    next_state_next = c ? inc : bus.current_state;
      NS_CALL: begin
        // Jump is taken even when the return address cannot be saved.
        push            = 1'b1;
        next_state_next = bus.cr_addr;
        err_set         = stack_full;
      end
      NS_RETURN: begin
        if (stack_empty) begin
          next_state_next = RESET_ADDR;
          err_set         = 1'b1;
        end else begin
          pop             = 1'b1;
          next_state_next = stack_dout;
        end
      end
      NS_RESTART: next_state_next = RESET_ADDR;
      default:    next_state_next = RESET_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_state_reg <= RESET_ADDR;
      stack_err_reg  <= 1'b0;
    end else begin
      next_state_reg <= next_state_next;
      if (err_set) begin
        stack_err_reg <= 1'b1;
      end
    end
  end

  micro_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (inc),
    .dout  (stack_dout),
    .depth (depth),
    .full  (stack_full),
    .empty (stack_empty)
  );

  assign bus.next_state  = next_state_reg;
  assign bus.stack_err   = stack_err_reg;
  assign bus.stack_depth = depth;

endmodule

// File: tb/tb_next_state_selector.sv
// Randomized and directed bench for next_state_selector against a queue-based
// behavioural model of the sequencing rules.
module tb_next_state_selector;
  import next_state_selector_pkg::*;

  localparam int AW = 10;
  localparam int SD = 4;

  logic clk;
  logic reset;

  next_state_selector_if #(.ADDR_W(AW), .STACK_DEPTH(SD)) sel_bus ();

  next_state_selector #(
    .ADDR_W      (AW),
    .STACK_DEPTH (SD),
    .RESET_STATE (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sel_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  int m_ns;
  int m_stack[$];
  bit m_err;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, got, exp, txn);
    end
  endtask

  // Model: one clock of the sequencer computed directly from the opcode rules.
  task automatic model_step(input bit rst, input int sel, input int cs, input bit iv,
                            input int csel, input int cr, input int cin, input int enc);
    int inc;
    bit c;
    inc = (cs + 1) % 1024;
    c   = ((cin >> csel) & 1) != (iv ? 1 : 0);
    if (rst) begin
      m_ns = 0;
      m_stack.delete();
      m_err = 0;
      return;
    end
    case (sel)
      0: m_ns = enc;
      1: m_ns = cr;
      2: m_ns = inc;
      3: m_ns = c ? cr : inc;
      4: m_ns = c ? inc : cs;
      5: begin
        if (m_stack.size() == SD) m_err = 1;
        else m_stack.push_back(inc);
        m_ns = cr;
      end
      6: begin
        if (m_stack.size() == 0) begin
          m_ns  = 0;
          m_err = 1;
        end else begin
          m_ns = m_stack.pop_back();
        end
      end
      default: m_ns = 0;
    endcase
  endtask

  task automatic do_cycle(input bit rst, input int sel, input int cs, input bit iv,
                          input int csel, input int cr, input int cin, input int enc);
    reset                 = rst;
    sel_bus.ns_sel        = 3'(sel);
    sel_bus.current_state = AW'(cs);
    sel_bus.inv           = iv;
    sel_bus.cond_sel      = 2'(csel);
    sel_bus.cr_addr       = AW'(cr);
    sel_bus.cond_in       = 4'(cin);
    sel_bus.encoder_state = AW'(enc);
    model_step(rst, sel, cs, iv, csel, cr, cin, enc);
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d rst=%0d sel=%0d cs=%0d cr=%0d cin=%0h inv=%0d -> ns=%0d depth=%0d err=%0d",
             txn, rst, sel, cs, cr, cin, iv, sel_bus.next_state, sel_bus.stack_depth,
             sel_bus.stack_err);
    check_val("next_state", int'(sel_bus.next_state), m_ns);
    check_val("stack_depth", int'(sel_bus.stack_depth), m_stack.size());
    check_val("stack_err", int'(sel_bus.stack_err), int'(m_err));
  endtask

  initial begin
    reset                 = 1'b1;
    sel_bus.ns_sel        = NS_INC;
    sel_bus.current_state = '0;
    sel_bus.inv           = 1'b0;
    sel_bus.cond_sel      = '0;
    sel_bus.cr_addr       = '0;
    sel_bus.cond_in       = '0;
    sel_bus.encoder_state = '0;
    m_ns  = 0;
    m_err = 0;

    do_cycle(1, 2, 0, 0, 0, 0, 0, 0);
    check_val("reset_ns", int'(sel_bus.next_state), 0);

    // Microstore follows next_state: INC walks 1,2,3.
    for (int i = 0; i < 3; i++) do_cycle(0, 2, m_ns, 0, 0, 0, 0, 0);
    check_val("inc_seq", int'(sel_bus.next_state), 3);
    do_cycle(0, 5, m_ns, 0, 0, 500, 0, 0);
    do_cycle(1, 2, m_ns, 0, 0, 0, 0, 0);
    check_val("mid_reset_depth", int'(sel_bus.stack_depth), 0);

    do_cycle(0, 3, 12, 0, 1, 20, 4'b0010, 0);
    check_val("cbr_taken", int'(sel_bus.next_state), 20);
    do_cycle(0, 3, 12, 1, 1, 20, 4'b0010, 0);
    check_val("cbr_inv", int'(sel_bus.next_state), 13);

    for (int i = 0; i < 3; i++) do_cycle(0, 4, 3, 0, 0, 0, 4'b1110, 0);
    check_val("wait_hold", int'(sel_bus.next_state), 3);
    do_cycle(0, 4, 3, 0, 0, 0, 4'b0001, 0);
    check_val("wait_done", int'(sel_bus.next_state), 4);

    do_cycle(0, 5, 26, 0, 0, 40, 0, 0);
    check_val("call_depth", int'(sel_bus.stack_depth), 1);
    do_cycle(0, 6, 42, 0, 0, 0, 0, 0);
    check_val("ret_addr", int'(sel_bus.next_state), 27);

    for (int i = 0; i < 5; i++) do_cycle(0, 5, 100 + 10 * i, 0, 0, 200 + 10 * i, 0, 0);
    check_val("ovf_jump", int'(sel_bus.next_state), 240);
    check_val("ovf_err", int'(sel_bus.stack_err), 1);
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 6, 300, 0, 0, 0, 0, 0);
      check_val("ret_order", int'(sel_bus.next_state), 131 - 10 * i);
    end
    do_cycle(0, 6, 300, 0, 0, 0, 0, 0);
    check_val("unf_ns", int'(sel_bus.next_state), 0);

    do_cycle(0, 2, 1023, 0, 0, 0, 0, 0);
    check_val("inc_wrap", int'(sel_bus.next_state), 0);
    do_cycle(0, 0, 55, 0, 0, 0, 0, 10);
    check_val("encode", int'(sel_bus.next_state), 10);
    do_cycle(1, 7, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      int cs;
      cs = ($urandom_range(0, 1) == 1) ? m_ns : int'($urandom_range(0, 1023));
      do_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 7), cs, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 15),
               $urandom_range(0, 1023));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
